// File: rtl/sync_event_rx_if.sv
// Event handshake bundle between sync_event_rx and its local consumer.
// Master (the decoder) drives ev_valid/ev_pending, slave drives ev_ready.
// ev_valid is a pure register decode; ev_ready never feeds back combinationally.
interface sync_event_rx_if #(
    parameter int CNT_W = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic [CNT_W-1:0] ev_pending;

    modport master (
        output ev_valid,
        output ev_pending,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_pending,
        output ev_ready
    );
endinterface

// File: rtl/sync_event_rx.sv
// Decodes edges of a synchronized level into queued events with a toggle ack back to the source.
// Latency: edge sampled at clock N is visible as ev_valid after N; a held ev_ready fires the next cycle.
// Backpressure: events queue up to 2^CNT_W-1; further edges without a same-cycle fire are dropped and flag ovf.
module sync_event_rx #(
    parameter int CNT_W      = 4,
    parameter int SETTLE_CYC = 3,
    parameter int EDGE_MODE  = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_sync_lvl,
    input  logic                 i_ovf_clr,
    output logic                 o_ack_lvl,
    output logic                 o_ovf,
    output logic                 o_settled,
    sync_event_rx_if.master      bus
);
    // Settle counter only has to reach SETTLE_CYC-1.
    localparam int          SW          = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t           r_state;
    logic [SW-1:0]    r_settle_cnt;
    logic             r_prev_lvl;
    logic [CNT_W-1:0] r_pending;
    logic             r_ack_lvl;
    logic             r_ovf;
    logic             r_settled;

    logic w_edge;
    logic w_fire;
    logic w_full;
    logic w_ovf_evt;
    logic w_settle_done;

    // Edges only count once the synchronizer output is trusted (RUN).
    assign w_edge        = (r_state == ST_RUN) &&
                           ((EDGE_MODE == 0) ? (i_sync_lvl ^ r_prev_lvl)
                                             : (i_sync_lvl & ~r_prev_lvl));
    assign w_fire        = (r_pending != '0) & bus.ev_ready;
    assign w_full        = (r_pending == '1);
    // A same-cycle fire frees the slot, so saturation only loses the edge without one.
    assign w_ovf_evt     = w_edge & ~w_fire & w_full;
    assign w_settle_done = (SETTLE_CYC == 0) || (r_settle_cnt == SETTLE_LAST);

    assign bus.ev_valid   = (r_pending != '0);
    assign bus.ev_pending = r_pending;
    assign o_ack_lvl      = r_ack_lvl;
    assign o_ovf          = r_ovf;
    assign o_settled      = r_settled;

    // Settle/run sequencing, pending-event counter, ack toggle and sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_prev_lvl   <= 1'b1;   // upstream synchronizer resets to 1
            r_pending    <= '0;
            r_ack_lvl    <= 1'b0;
            r_ovf        <= 1'b0;
            r_settled    <= 1'b0;
        end else begin
            r_prev_lvl <= i_sync_lvl;

            case (r_state)
                ST_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                    if (w_settle_done) begin
                        r_state   <= ST_RUN;
                        r_settled <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_settled <= 1'b1;
                end
            endcase

            if (w_edge && !w_fire && !w_full) begin
                r_pending <= r_pending + 1'b1;
            end else if (w_fire && !w_edge) begin
                r_pending <= r_pending - 1'b1;
            end

            if (w_fire) begin
                r_ack_lvl <= ~r_ack_lvl;
            end

            // Set beats clear when both happen together.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end
endmodule
